fb_wr_arbiter: RTL and testbench
================================

FB_WR_ARBITER -- requirements
Module: fb_wr_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 768, frame buffer entries per frame.
REQ-002 SHALL have parameter ADDR_W, default 10, write address width.
REQ-003 SHALL have parameter CLEAR_COLOR, default 8'h00, 3:3:2 fill value used during clear.
REQ-004 SHALL have port vgaclk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port frame_start, input, 1, one-cycle pulse at the start of each frame.
REQ-007 SHALL have ports req_gfx (in, 1), gfx_addr (in, ADDR_W), gfx_data (in, 8), gfx_gnt (out, 1): graphics requester.
REQ-008 SHALL have ports req_ovl (in, 1), ovl_addr (in, ADDR_W), ovl_data (in, 8), ovl_gnt (out, 1): overlay requester.
REQ-009 SHALL have ports we (out, 1), wr_addr (out, ADDR_W), wr_data (out, 8): ping-pong buffer write port.
REQ-010 SHALL have port clear_busy, output, 1, high while the clear sweep runs.
REQ-011 SHALL have port overrun_cnt, output, 8, saturating count of frames whose clear did not finish.

Function
REQ-012 SHALL implement FSM states IDLE, CLEAR, DRAW; reset state IDLE.
REQ-013 IDLE: no grants, we=0; frame_start -> CLEAR.
REQ-014 CLEAR: internal counter clr_addr starts at 0; one write per cycle, wr_addr=clr_addr, wr_data=CLEAR_COLOR; gfx_gnt=ovl_gnt=0.
REQ-015 CLEAR: write with clr_addr=DEPTH-1 is the last; next state DRAW; clear takes exactly DEPTH cycles.
REQ-016 frame_start during CLEAR: clr_addr restarts at 0, state stays CLEAR, overrun_cnt increments (saturates at 255).
REQ-017 DRAW: gfx_gnt/ovl_gnt combinational from req_* in the same cycle; at most one grant per cycle.
REQ-018 DRAW single request: that requester is granted.
REQ-019 DRAW both requesting: round-robin; grant the requester not granted most recently; last-grant pointer updates only on a grant.
REQ-020 Last-grant pointer reset value = overlay, so graphics wins the first tie after reset.
REQ-021 Granted addr/data SHALL be registered onto wr_addr/wr_data with we=1 one cycle after the grant (latency 1); no grant -> we=0 next cycle, wr_addr/wr_data hold.
REQ-022 CLEAR writes also registered: we high for DEPTH consecutive cycles starting one cycle after CLEAR entry.
REQ-023 DRAW: frame_start -> CLEAR; a grant in that same cycle is suppressed (no gnt).
REQ-024 clear_busy = 1 exactly while state is CLEAR.
REQ-025 Requester addresses >= DEPTH SHALL be granted but the write dropped (we=0).

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, clr_addr 0, we 0, wr_addr 0, wr_data 0, overrun_cnt 0, pointer overlay; gnt outputs 0.
REQ-027 Reset asserted mid-CLEAR or mid-DRAW SHALL abort immediately; no pending write is issued after release.
REQ-028 After rst_n rises, block stays IDLE until the first frame_start.

Configuration
REQ-029 Macro FB_CLEAR_EN defined: CLEAR state, clr_addr, clear_busy and overrun_cnt behave per REQ-014..016, REQ-024.
REQ-030 FB_CLEAR_EN undefined: frame_start goes IDLE/DRAW -> DRAW directly, no clear writes, clear_busy tied 0, overrun_cnt tied 0.

Verification
REQ-031 Reset, frame_start pulse, no requests -> we high 768 cycles, wr_addr 0..767, wr_data 8'h00, clear_busy falls, state DRAW.
REQ-032 DRAW, req_gfx=req_ovl=1 held 4 cycles -> grants gfx, ovl, gfx, ovl; writes appear one cycle later with matching addr/data.
REQ-033 Second frame_start 100 cycles into CLEAR -> wr_addr returns to 0, overrun_cnt=1, full 768-write sweep follows.
REQ-034 DRAW, req_gfx=1 gfx_addr=10'd800 -> gfx_gnt=1, we stays 0 next cycle.
REQ-035 rst_n low at clear cycle 300 -> we=0 immediately, all outputs reset; after release no writes until frame_start.
REQ-036 Build without FB_CLEAR_EN, frame_start then req_ovl=1 ovl_addr=5 ovl_data=8'hE0 -> ovl_gnt same cycle, we=1 wr_addr=5 wr_data=8'hE0 next cycle, clear_busy never high.

Source files
------------

// File: rtl/fb_wr_arbiter.sv
// fb_wr_arbiter: frame-buffer write arbiter; clears the buffer on frame start (FB_CLEAR_EN), then round-robins gfx/ovl writes.
// Latency: grants are combinational in the request cycle; the buffer write (we/wr_addr/wr_data) follows 1 cycle later.
// Backpressure: the buffer port never stalls; a requester that gets no grant must hold its request.
module fb_wr_arbiter #(
  parameter int unsigned DEPTH       = 768,
  parameter int unsigned ADDR_W      = 10,
  parameter logic [7:0]  CLEAR_COLOR = 8'h00
) (
  input  logic              vgaclk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              req_gfx,
  input  logic [ADDR_W-1:0] gfx_addr,
  input  logic [7:0]        gfx_data,
  output logic              gfx_gnt,
  input  logic              req_ovl,
  input  logic [ADDR_W-1:0] ovl_addr,
  input  logic [7:0]        ovl_data,
  output logic              ovl_gnt,
  output logic              we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              clear_busy,
  output logic [7:0]        overrun_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;

  // Last-grant pointer values
  localparam logic PTR_GFX = 1'b0;
  localparam logic PTR_OVL = 1'b1;

`ifdef FB_CLEAR_EN
  // A frame start always begins with a clear sweep
  localparam logic [1:0]        ST_FRAME = ST_CLEAR;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
`else
  // Without clearing, a frame start goes straight to drawing
  localparam logic [1:0]        ST_FRAME = ST_DRAW;
`endif

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              grant_ok, gfx_in_range, ovl_in_range;

`ifdef FB_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [7:0]        ovr_q, ovr_d;
`endif

  // Grants only in DRAW; the frame_start cycle is reserved for the frame boundary
  assign grant_ok     = (state_q == ST_DRAW) && !frame_start;
  assign gfx_gnt      = grant_ok && req_gfx && (!req_ovl || (last_q == PTR_OVL));
  assign ovl_gnt      = grant_ok && req_ovl && (!req_gfx || (last_q == PTR_GFX));
  // Out-of-range addresses are still granted, but their write is dropped
  assign gfx_in_range = 32'(gfx_addr) < DEPTH;
  assign ovl_in_range = 32'(ovl_addr) < DEPTH;

  assign we      = we_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

`ifdef FB_CLEAR_EN
  assign clear_busy  = (state_q == ST_CLEAR);
  assign overrun_cnt = ovr_q;
`else
  assign clear_busy  = 1'b0;
  assign overrun_cnt = 8'h00;
`endif

  // Next-state: FSM, round-robin pointer and the registered write port
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    we_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef FB_CLEAR_EN
    clr_addr_d = clr_addr_q;
    ovr_d      = ovr_q;
`endif
    if (gfx_gnt) begin
      last_d = PTR_GFX;
      if (gfx_in_range) begin
        we_d      = 1'b1;
        wr_addr_d = gfx_addr;
        wr_data_d = gfx_data;
      end
    end else if (ovl_gnt) begin
      last_d = PTR_OVL;
      if (ovl_in_range) begin
        we_d      = 1'b1;
        wr_addr_d = ovl_addr;
        wr_data_d = ovl_data;
      end
    end
    case (state_q)
      ST_IDLE, ST_DRAW: begin
        if (frame_start) begin
          state_d = ST_FRAME;
`ifdef FB_CLEAR_EN
          clr_addr_d = '0;
`endif
        end
      end
      ST_CLEAR: begin
`ifdef FB_CLEAR_EN
        we_d      = 1'b1;
        wr_addr_d = clr_addr_q;
        wr_data_d = CLEAR_COLOR;
        if (frame_start) begin
          // New frame arrived before the sweep finished: restart and log it
          clr_addr_d = '0;
          if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
        end else if (clr_addr_q == CLR_LAST) begin
          clr_addr_d = '0;
          state_d    = ST_DRAW;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
`else
        // Unreachable without clearing; recover to drawing
        state_d = ST_DRAW;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Core state registers; reset aborts any pending write
  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= PTR_OVL;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef FB_CLEAR_EN
  // Clear sweep address and overrun counter
  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr_q <= '0;
      ovr_q      <= 8'h00;
    end else begin
      clr_addr_q <= clr_addr_d;
      ovr_q      <= ovr_d;
    end
  end
`endif

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// tb_fb_wr_arbiter: directed stimulus for fb_wr_arbiter with a write scoreboard.
// Expected writes carry the cycle they must appear in; a negedge monitor pops and compares.
// Builds with or without FB_CLEAR_EN; the clear-sweep sections follow the macro.
module tb_fb_wr_arbiter;

  localparam int         DEPTH     = 768;
  localparam logic [7:0] CLR_COLOR = 8'h00;

  logic       vgaclk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic       req_gfx, req_ovl;
  logic [9:0] gfx_addr, ovl_addr;
  logic [7:0] gfx_data, ovl_data;
  logic       gfx_gnt, ovl_gnt, we, clear_busy;
  logic [9:0] wr_addr;
  logic [7:0] wr_data, overrun_cnt;

  typedef struct {
    logic [9:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  wr_t sb[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  fb_wr_arbiter dut (
    .vgaclk      (vgaclk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .req_gfx     (req_gfx),
    .gfx_addr    (gfx_addr),
    .gfx_data    (gfx_data),
    .gfx_gnt     (gfx_gnt),
    .req_ovl     (req_ovl),
    .ovl_addr    (ovl_addr),
    .ovl_data    (ovl_data),
    .ovl_gnt     (ovl_gnt),
    .we          (we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .clear_busy  (clear_busy),
    .overrun_cnt (overrun_cnt)
  );

  always #5 vgaclk = ~vgaclk;

  always @(posedge vgaclk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Monitor: every write the DUT presents must match the head of the scoreboard
  always @(negedge vgaclk) begin
    if (we === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%0h cycle=%0d want=no write", wr_addr, wr_data, cyc);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
        chk("wr_cycle", cyc, e.c);
      end
    end
  end

  // One clock of stimulus: drive after the edge, check grants/busy mid-cycle,
  // and queue the writes that must appear next cycle.
  task automatic cyc_drive(input logic fs,
                           input logic rg, input logic [9:0] ga, input logic [7:0] gd,
                           input logic ro, input logic [9:0] oa, input logic [7:0] od,
                           input logic eg, input logic eo, input logic eb,
                           input int clr, input string tag);
    @(posedge vgaclk);
    #1;
    frame_start = fs;
    req_gfx  = rg; gfx_addr = ga; gfx_data = gd;
    req_ovl  = ro; ovl_addr = oa; ovl_data = od;
    if (eg && (int'(ga) < DEPTH)) sb.push_back('{ga, gd, cyc + 1});
    if (eo && (int'(oa) < DEPTH)) sb.push_back('{oa, od, cyc + 1});
    if (clr >= 0) sb.push_back('{10'(clr), CLR_COLOR, cyc + 1});
    @(negedge vgaclk);
    chk({tag, "_gfx_gnt"}, 32'(gfx_gnt), 32'(eg));
    chk({tag, "_ovl_gnt"}, 32'(ovl_gnt), 32'(eo));
    chk({tag, "_busy"}, 32'(clear_busy), 32'(eb));
  endtask

  // Full clear sweep with both requesters asking (they must never be granted)
  task automatic clear_sweep();
    for (int i = 0; i < DEPTH; i++)
      cyc_drive(1'b0, 1'b1, 10'd1, 8'h11, 1'b1, 10'd2, 8'h22, 1'b0, 1'b0, 1'b1, i, "clr");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},      32'(we), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_busy"},    32'(clear_busy), 0);
    chk({tag, "_ovr"},     32'(overrun_cnt), 0);
    chk({tag, "_gfx_gnt"}, 32'(gfx_gnt), 0);
    chk({tag, "_ovl_gnt"}, 32'(ovl_gnt), 0);
  endtask

  // Round-robin tie: gfx addr/data 10+i, ovl 20+i; expected winners hand-derived
  logic tie_g [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0;
    req_gfx = 1'b0; gfx_addr = '0; gfx_data = '0;
    req_ovl = 1'b0; ovl_addr = '0; ovl_data = '0;

    // Reset state, with a request present
    repeat (2) @(posedge vgaclk);
    #1 req_gfx = 1'b1; gfx_addr = 10'd7;
    #1 chk_reset_outputs("rst");
    @(negedge vgaclk) rst_n = 1'b1;

    // IDLE ignores requests until the first frame start
    repeat (4) cyc_drive(1'b0, 1'b1, 10'd7, 8'h77, 1'b1, 10'd8, 8'h88, 1'b0, 1'b0, 1'b0, -1, "idle");
    cyc_drive(1'b1, 1'b1, 10'd7, 8'h77, 1'b1, 10'd8, 8'h88, 1'b0, 1'b0, 1'b0, -1, "fs_idle");
`ifdef FB_CLEAR_EN
    clear_sweep();
`endif

    // Single overlay request: same-cycle grant, write next cycle
    cyc_drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b1, 10'd5, 8'hE0, 1'b0, 1'b1, 1'b0, -1, "ovl_only");

    // Tie held for 4 cycles: gfx, ovl, gfx, ovl
    for (int i = 0; i < 4; i++)
      cyc_drive(1'b0, 1'b1, 10'(10 + i), 8'(16 + i), 1'b1, 10'(20 + i), 8'(32 + i),
                tie_g[i], !tie_g[i], 1'b0, -1, "tie");
    cyc_drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b0, -1, "quiet");

    // Out-of-range gfx address: granted, write dropped, outputs hold last write (ovl 23 / 8'h23)
    cyc_drive(1'b0, 1'b1, 10'd800, 8'h55, 1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 1'b0, -1, "oor800");
    cyc_drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b0, -1, "after_oor");
    chk("hold_addr", 32'(wr_addr), 23);
    chk("hold_data", 32'(wr_data), 32'h23);

    // Address boundary: 767 written, 768 dropped
    cyc_drive(1'b0, 1'b1, 10'd767, 8'hA7, 1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 1'b0, -1, "addr767");
    cyc_drive(1'b0, 1'b1, 10'd768, 8'hA8, 1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 1'b0, -1, "addr768");

    // Dropped gfx grant still moved the pointer, so the tie goes to ovl
    cyc_drive(1'b0, 1'b1, 10'd30, 8'h30, 1'b1, 10'd40, 8'h40, 1'b0, 1'b1, 1'b0, -1, "tie_after_drop");

    // Frame start in DRAW suppresses the grant
    cyc_drive(1'b1, 1'b1, 10'd60, 8'h60, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b0, -1, "fs_draw");
`ifdef FB_CLEAR_EN
    // Second frame start 100 cycles into the clear: restart sweep, count overrun
    for (int i = 0; i < 100; i++)
      cyc_drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1, i, "clr_pre");
    cyc_drive(1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1, 100, "ovr_fs");
    clear_sweep();
    chk("overrun_1", 32'(overrun_cnt), 1);
`endif
    // Pointer is ovl here, so gfx wins; pointer becomes gfx
    cyc_drive(1'b0, 1'b1, 10'd70, 8'h70, 1'b1, 10'd71, 8'h71, 1'b1, 1'b0, 1'b0, -1, "tie_post_fs");

    // Reset mid-DRAW with a grant pending: the write must never appear
    @(posedge vgaclk);
    #1 req_gfx = 1'b1; gfx_addr = 10'd50; gfx_data = 8'h50; req_ovl = 1'b0; frame_start = 1'b0;
    @(negedge vgaclk);
    chk("pre_rst_gnt", 32'(gfx_gnt), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    repeat (2) @(posedge vgaclk);
    @(negedge vgaclk) rst_n = 1'b1;
    repeat (3) cyc_drive(1'b0, 1'b1, 10'd50, 8'h50, 1'b1, 10'd51, 8'h51, 1'b0, 1'b0, 1'b0, -1, "idle_post_rst");
    cyc_drive(1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b0, -1, "fs_idle2");
`ifdef FB_CLEAR_EN
    clear_sweep();
`endif
    // Pointer back to its reset value (ovl): gfx wins the first tie
    cyc_drive(1'b0, 1'b1, 10'd90, 8'h90, 1'b1, 10'd91, 8'h91, 1'b1, 1'b0, 1'b0, -1, "tie_after_rst");
    repeat (2) cyc_drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b0, -1, "drain");

    chk("sb_empty", sb.size(), 0);
    chk("ovr_final", 32'(overrun_cnt), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
